// File: rtl/calendar_pkg.sv
// Shared types, month constants and date helpers for calendar_counter.
// CALENDAR_DOY_OUT_EN adds the day-of-year offset table and BCD helpers.
package calendar_pkg;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   localparam logic [3:0] JAN = 4'd1;
   localparam logic [3:0] FEB = 4'd2;
   localparam logic [3:0] MAR = 4'd3;
   localparam logic [3:0] APR = 4'd4;
   localparam logic [3:0] MAY = 4'd5;
   localparam logic [3:0] JUN = 4'd6;
   localparam logic [3:0] JUL = 4'd7;
   localparam logic [3:0] AUG = 4'd8;
   localparam logic [3:0] SEP = 4'd9;
   localparam logic [3:0] OCT = 4'd10;
   localparam logic [3:0] NOV = 4'd11;
   localparam logic [3:0] DEC = 4'd12;

   localparam logic [3:0] BLANK = 4'hF;

   function automatic logic [6:0] bcd2_to_bin(input bcd2_t v);
      logic [7:0] b;
      b = 8'(v.tens) * 8'd10 + 8'(v.ones);
      return b[6:0];
   endfunction

   function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                 input logic leap);
      case (month)
         APR, JUN, SEP, NOV: return 5'd30;
         FEB:                return 5'd28 + {4'd0, leap};
         default:            return 5'd31;
      endcase
   endfunction

   function automatic bcd2_t bin_to_bcd2(input logic [4:0] v);
      bcd2_t r;
      r.tens = 4'(v / 5'd10);
      r.ones = 4'(v % 5'd10);
      return r;
   endfunction

   // Last day of a BCD month, itself as BCD so it compares directly.
   function automatic bcd2_t last_day(input bcd2_t month, input logic leap);
      logic [6:0] m;
      m = bcd2_to_bin(month);
      return bin_to_bcd2(days_in_month(m[3:0], leap));
   endfunction

`ifdef CALENDAR_DOY_OUT_EN
   function automatic logic [8:0] cum_days(input logic [3:0] m);
      case (m)
         JAN:     return 9'd0;
         FEB:     return 9'd31;
         MAR:     return 9'd59;
         APR:     return 9'd90;
         MAY:     return 9'd120;
         JUN:     return 9'd151;
         JUL:     return 9'd181;
         AUG:     return 9'd212;
         SEP:     return 9'd243;
         OCT:     return 9'd273;
         NOV:     return 9'd304;
         DEC:     return 9'd334;
         default: return 9'd0;
      endcase
   endfunction

   function automatic logic [11:0] bin_to_bcd3(input logic [8:0] v);
      return {4'(v / 9'd100), 4'((v / 9'd10) % 9'd10), 4'(v % 9'd10)};
   endfunction

   function automatic logic [11:0] doy_of(input bcd2_t month,
                                          input bcd2_t day,
                                          input logic leap);
      logic [6:0] m;
      logic [6:0] d;
      logic [8:0] n;
      m = bcd2_to_bin(month);
      d = bcd2_to_bin(day);
      n = cum_days(m[3:0]) + {2'b0, d} + {8'b0, leap && (m > 7'd2)};
      return bin_to_bcd3(n);
   endfunction

   function automatic logic [11:0] bcd3_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd9) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4]  = 4'd0;
            r[11:8] = v[11:8] + 4'd1;
         end
      end
      return r;
   endfunction
`endif

endpackage

// File: rtl/calendar_counter_bcd_digit_pair.sv
// Two-digit BCD register: load, synchronous set-to-01, or increment,
// with a tens-digit blanked copy registered alongside.
module bcd_digit_pair
   import calendar_pkg::*;
#(
   parameter bcd2_t      RESET_VAL  = 8'h01,
   parameter logic [3:0] BLANK_CODE = BLANK
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       set_one,
   input  logic       load,
   input  bcd2_t      ld_val,
   output bcd2_t      q,
   output logic [3:0] seg_tens
);

   bcd2_t nxt;

   always_comb begin
      nxt = q;
      if (load) begin
         nxt = ld_val;
      end else if (set_one) begin
         nxt = bcd2_t'(8'h01);
      end else if (inc) begin
         if (q.ones == 4'd9) begin
            nxt.ones = 4'd0;
            nxt.tens = q.tens + 4'd1;
         end else begin
            nxt.ones = q.ones + 4'd1;
         end
      end
   end

   // Blanking is derived from the next value so it never lags the digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q        <= RESET_VAL;
         seg_tens <= (RESET_VAL.tens == 4'd0) ? BLANK_CODE : RESET_VAL.tens;
      end else begin
         q        <= nxt;
         seg_tens <= (nxt.tens == 4'd0) ? BLANK_CODE : nxt.tens;
      end
   end

endmodule

// File: rtl/calendar_counter.sv
// BCD month/day calendar advancing one day per tick, with load checking.
// Define CALENDAR_DOY_OUT_EN to add the BCD day-of-year output doy.
module calendar_counter
   import calendar_pkg::*;
#(
   parameter int         RESET_MONTH = 1,
   parameter int         RESET_DAY   = 1,
   parameter logic [3:0] BLANK_CODE  = BLANK
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        day_tick,
   input  logic        leap,
   input  logic        load,
   input  logic [7:0]  ld_month,
   input  logic [7:0]  ld_day,
   output logic [3:0]  month10,
   output logic [3:0]  month1,
   output logic [3:0]  day10,
   output logic [3:0]  day1,
   output logic [3:0]  seg_month10,
   output logic [3:0]  seg_day10,
   output logic        year_wrap,
`ifdef CALENDAR_DOY_OUT_EN
   output logic [11:0] doy,
`endif
   output logic        load_err
);

   localparam bcd2_t RST_M = '{tens: 4'(RESET_MONTH / 10),
                               ones: 4'(RESET_MONTH % 10)};
   localparam bcd2_t RST_D = '{tens: 4'(RESET_DAY / 10),
                               ones: 4'(RESET_DAY % 10)};

   bcd2_t month;
   bcd2_t day;
   bcd2_t ldm;
   bcd2_t ldd;
   logic  load_ok;
   logic  tick;
   logic  at_end;
   logic  is_dec;

   assign ldm = bcd2_t'(ld_month);
   assign ldd = bcd2_t'(ld_day);

   assign load_ok = (ldm.tens <= 4'd9) && (ldm.ones <= 4'd9) &&
                    (ldd.tens <= 4'd9) && (ldd.ones <= 4'd9) &&
                    (ld_month >= 8'h01) && (ld_month <= 8'h12) &&
                    (ld_day >= 8'h01) && (ldd <= last_day(ldm, leap));

   // A load in the same cycle always swallows the tick.
   assign tick   = day_tick && !load;
   assign at_end = day >= last_day(month, leap);
   assign is_dec = month == bcd2_t'(8'h12);

   bcd_digit_pair #(.RESET_VAL(RST_D), .BLANK_CODE(BLANK_CODE)) u_day (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (tick && !at_end),
      .set_one  (tick && at_end),
      .load     (load && load_ok),
      .ld_val   (ldd),
      .q        (day),
      .seg_tens (seg_day10)
   );

   bcd_digit_pair #(.RESET_VAL(RST_M), .BLANK_CODE(BLANK_CODE)) u_month (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (tick && at_end && !is_dec),
      .set_one  (tick && at_end && is_dec),
      .load     (load && load_ok),
      .ld_val   (ldm),
      .q        (month),
      .seg_tens (seg_month10)
   );

   assign month10 = month.tens;
   assign month1  = month.ones;
   assign day10   = day.tens;
   assign day1    = day.ones;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         year_wrap <= 1'b0;
         load_err  <= 1'b0;
      end else begin
         year_wrap <= tick && at_end && is_dec;
         load_err  <= load && !load_ok;
      end
   end

`ifdef CALENDAR_DOY_OUT_EN
   localparam logic [11:0] RST_DOY = doy_of(RST_M, RST_D, 1'b0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         doy <= RST_DOY;
      end else if (load && load_ok) begin
         doy <= doy_of(ldm, ldd, leap);
      end else if (tick && at_end && is_dec) begin
         doy <= 12'h001;
      end else if (tick) begin
         doy <= bcd3_inc(doy);
      end
   end
`endif

endmodule

// File: tb/tb_calendar_counter.sv
// Directed self-checking bench for calendar_counter.
// Also covers doy when built with CALENDAR_DOY_OUT_EN.
module tb_calendar_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        day_tick;
   logic        leap;
   logic        load;
   logic [7:0]  ld_month;
   logic [7:0]  ld_day;
   logic [3:0]  month10, month1, day10, day1;
   logic [3:0]  seg_month10, seg_day10;
   logic        year_wrap;
   logic        load_err;
   logic [15:0] date;
`ifdef CALENDAR_DOY_OUT_EN
   logic [11:0] doy;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign date = {month10, month1, day10, day1};

   calendar_counter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .day_tick    (day_tick),
      .leap        (leap),
      .load        (load),
      .ld_month    (ld_month),
      .ld_day      (ld_day),
      .month10     (month10),
      .month1      (month1),
      .day10       (day10),
      .day1        (day1),
      .seg_month10 (seg_month10),
      .seg_day10   (seg_day10),
      .year_wrap   (year_wrap),
`ifdef CALENDAR_DOY_OUT_EN
      .doy         (doy),
`endif
      .load_err    (load_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [15:0] md);
      load     = 1'b1;
      ld_month = md[15:8];
      ld_day   = md[7:0];
      cyc();
      load = 1'b0;
   endtask

   task automatic do_tick();
      day_tick = 1'b1;
      cyc();
      day_tick = 1'b0;
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      day_tick = 1'b0;
      leap     = 1'b0;
      load     = 1'b0;
      ld_month = 8'h00;
      ld_day   = 8'h00;
      repeat (2) cyc();
      checks++;
      if (date !== 16'h0101) begin
         failures++;
         $display("FAIL reset_date got=%h exp=0101", date);
      end
      checks++;
      if ({seg_month10, seg_day10, year_wrap, load_err} !== 10'b1111_1111_00) begin
         failures++;
         $display("FAIL reset_seg got=%h%h wrap=%b err=%b exp=FF 0 0",
                  seg_month10, seg_day10, year_wrap, load_err);
      end
`ifdef CALENDAR_DOY_OUT_EN
      checks++;
      if (doy !== 12'h001) begin
         failures++;
         $display("FAIL reset_doy got=%h exp=001", doy);
      end
`endif
      rst_n = 1'b1;
      repeat (2) cyc();
      checks++;
      if (date !== 16'h0101 || {seg_month10, seg_day10} !== 8'hFF) begin
         failures++;
         $display("FAIL idle_after_reset got=%h seg=%h%h exp=0101 FF",
                  date, seg_month10, seg_day10);
      end
   endtask

   typedef struct {
      logic        lp;
      logic [15:0] ld;
      logic [15:0] exp;
   } vec_t;

   task automatic test_month_end();
      vec_t v[3];
      logic [7:0] seg_exp;
      v[0] = '{1'b0, 16'h0131, 16'h0201};
      v[1] = '{1'b0, 16'h0228, 16'h0301};
      v[2] = '{1'b1, 16'h0228, 16'h0229};
      for (int i = 0; i < 3; i++) begin
         leap = v[i].lp;
         do_load(v[i].ld);
         checks++;
         if (date !== v[i].ld || load_err !== 1'b0) begin
            failures++;
            $display("FAIL month_end_load%0d got=%h err=%b exp=%h 0",
                     i, date, load_err, v[i].ld);
         end
         do_tick();
         seg_exp[7:4] = (v[i].exp[15:12] == 4'd0) ? 4'hF : v[i].exp[15:12];
         seg_exp[3:0] = (v[i].exp[7:4] == 4'd0) ? 4'hF : v[i].exp[7:4];
         checks++;
         if (date !== v[i].exp || {seg_month10, seg_day10} !== seg_exp) begin
            failures++;
            $display("FAIL month_end_tick%0d got=%h seg=%h%h exp=%h seg=%h",
                     i, date, seg_month10, seg_day10, v[i].exp, seg_exp);
         end
      end
      do_tick();
      checks++;
      if (date !== 16'h0301) begin
         failures++;
         $display("FAIL leap_feb29_tick got=%h exp=0301", date);
      end
      leap = 1'b1;
      do_load(16'h0229);
      leap = 1'b0;
      cyc();
      checks++;
      if (date !== 16'h0229) begin
         failures++;
         $display("FAIL leap_drop_hold got=%h exp=0229", date);
      end
      do_tick();
      checks++;
      if (date !== 16'h0301) begin
         failures++;
         $display("FAIL leap_drop_tick got=%h exp=0301", date);
      end
   endtask

   task automatic test_year_wrap();
      leap = 1'b0;
      do_load(16'h1231);
      checks++;
      if (date !== 16'h1231 || {seg_month10, seg_day10} !== 8'h13 ||
          year_wrap !== 1'b0) begin
         failures++;
         $display("FAIL dec31_load got=%h seg=%h%h wrap=%b exp=1231 13 0",
                  date, seg_month10, seg_day10, year_wrap);
      end
      do_tick();
      checks++;
      if (date !== 16'h0101 || year_wrap !== 1'b1) begin
         failures++;
         $display("FAIL year_wrap_tick got=%h wrap=%b exp=0101 1",
                  date, year_wrap);
      end
      cyc();
      checks++;
      if (date !== 16'h0101 || year_wrap !== 1'b0) begin
         failures++;
         $display("FAIL year_wrap_pulse got=%h wrap=%b exp=0101 0",
                  date, year_wrap);
      end
   endtask

   task automatic test_load_err();
      logic [15:0] bad[6];
      bad[0] = 16'h0431;
      bad[1] = 16'h1301;
      bad[2] = 16'h0005;
      bad[3] = 16'h0229;
      bad[4] = 16'h0A01;
      bad[5] = 16'h0100;
      leap = 1'b0;
      do_load(16'h0615);
      for (int i = 0; i < 6; i++) begin
         do_load(bad[i]);
         checks++;
         if (date !== 16'h0615 || load_err !== 1'b1) begin
            failures++;
            $display("FAIL load_err%0d ld=%h got=%h err=%b exp=0615 1",
                     i, bad[i], date, load_err);
         end
         cyc();
         checks++;
         if (load_err !== 1'b0) begin
            failures++;
            $display("FAIL load_err_pulse%0d got=%b exp=0", i, load_err);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_load(16'h0101);
      day_tick = 1'b1;
      do_load(16'h0615);
      day_tick = 1'b0;
      checks++;
      if (date !== 16'h0615) begin
         failures++;
         $display("FAIL load_beats_tick got=%h exp=0615", date);
      end
      day_tick = 1'b1;
      do_load(16'h1301);
      day_tick = 1'b0;
      checks++;
      if (date !== 16'h0615 || load_err !== 1'b1) begin
         failures++;
         $display("FAIL bad_load_drops_tick got=%h err=%b exp=0615 1",
                  date, load_err);
      end
      day_tick = 1'b1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if (date !== 16'h0101 || {seg_month10, seg_day10} !== 8'hFF) begin
         failures++;
         $display("FAIL async_reset got=%h seg=%h%h exp=0101 FF",
                  date, seg_month10, seg_day10);
      end
      cyc();
      day_tick = 1'b0;
      rst_n    = 1'b1;
      cyc();
      checks++;
      if (date !== 16'h0101) begin
         failures++;
         $display("FAIL after_async_reset got=%h exp=0101", date);
      end
   endtask

   task automatic test_full_year(input logic lp);
      int n;
      int wraps;
      n     = lp ? 366 : 365;
      wraps = 0;
      leap  = lp;
      day_tick = 1'b1;
      for (int i = 0; i < n; i++) begin
         cyc();
         if (year_wrap === 1'b1) wraps++;
         if (i == n - 2) begin
            checks++;
            if (date !== 16'h1231) begin
               failures++;
               $display("FAIL year%0d_dec31 got=%h exp=1231", n, date);
            end
`ifdef CALENDAR_DOY_OUT_EN
            checks++;
            if (doy !== (lp ? 12'h366 : 12'h365)) begin
               failures++;
               $display("FAIL year%0d_doy got=%h exp=%0d", n, doy, n);
            end
`endif
         end
      end
      day_tick = 1'b0;
      cyc();
      checks++;
      if (date !== 16'h0101 || wraps != 1) begin
         failures++;
         $display("FAIL year%0d_end got=%h wraps=%0d exp=0101 1",
                  n, date, wraps);
      end
`ifdef CALENDAR_DOY_OUT_EN
      checks++;
      if (doy !== 12'h001) begin
         failures++;
         $display("FAIL year%0d_doy_wrap got=%h exp=001", n, doy);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_month_end();
      test_year_wrap();
      test_load_err();
      test_back_to_back();
      test_full_year(1'b1);
      test_full_year(1'b0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
